// File: rtl/column_skewer.sv
// column_skewer: input-staging block for the systolic array.
// Fans each accepted row vector into LENGTH lanes, delaying lane k by
// BASE_DELAY+k enabled cycles so the PE grid sees a diagonal wavefront.
// A small FSM tracks the end of a block and pulses done when the final
// sample reaches the last lane.
// Optional build macro: COLUMN_SKEW_HOLD_EN -- when defined, a lane output
// keeps its previous data on a bubble instead of dropping to zero.
//
// state  | meaning
// IDLE   | no block in flight, ready for the first vector
// STREAM | block open, more vectors (or bubbles) expected
// DRAIN  | last vector accepted, waiting for it to leave the last lane
module column_skewer #(
  parameter int LENGTH     = 4,
  parameter int DATA_WIDTH = 16,
  parameter int BASE_DELAY = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         enable_i,
  input  logic                         in_valid_i,
  input  logic                         in_last_i,
  input  logic [LENGTH*DATA_WIDTH-1:0] in_i,
  output logic                         in_ready_o,
  output logic [LENGTH*DATA_WIDTH-1:0] out_o,
  output logic [LENGTH-1:0]            out_valid_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int MAXD = BASE_DELAY + LENGTH - 1;
  localparam int CW   = $clog2(MAXD + 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          accept;

  assign in_ready_o = (state_q != DRAIN);
  assign accept     = enable_i & in_valid_i & in_ready_o;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = done_q;

  // FSM state, drain counter and done pulse registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; done is only ever a single-cycle pulse, so it
  // defaults low even when enable is held off.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (enable_i) begin
      case (state_q)
        IDLE, STREAM: begin
          if (accept) begin
            if (in_last_i) begin
              if (MAXD == 1) begin
                // Single-stage array: the last sample is already out.
                state_d = IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = DRAIN;
                cnt_d   = CW'(MAXD - 1);
              end
            end else begin
              state_d = STREAM;
            end
          end
        end
        DRAIN: begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < LENGTH; k++) begin : g_lane
    localparam int D = BASE_DELAY + k;

    logic [D-1:0]          vld_q;
    logic [DATA_WIDTH-1:0] dat_q [D];
    logic [DATA_WIDTH-1:0] lane_d;

    // Non-accepted cycles push a zero bubble into the chain.
    assign lane_d = accept ? in_i[k*DATA_WIDTH +: DATA_WIDTH] : '0;

`ifdef COLUMN_SKEW_HOLD_EN
    logic last_in_vld;
    if (D == 1) begin : g_single
      assign last_in_vld = accept;
    end else begin : g_multi
      assign last_in_vld = vld_q[D-2];
    end
`endif

    // Lane delay chain; stage D-1 drives the lane output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q <= '0;
        for (int s = 0; s < D; s++) dat_q[s] <= '0;
      end else if (enable_i) begin
        vld_q[0] <= accept;
        dat_q[0] <= lane_d;
        for (int s = 1; s < D; s++) begin
          vld_q[s] <= vld_q[s-1];
          dat_q[s] <= dat_q[s-1];
        end
`ifdef COLUMN_SKEW_HOLD_EN
        if (!last_in_vld) dat_q[D-1] <= dat_q[D-1];
`endif
      end
    end

    assign out_o[k*DATA_WIDTH +: DATA_WIDTH] = dat_q[D-1];
    assign out_valid_o[k]                    = vld_q[D-1];
  end

endmodule
